// File: rtl/pc_trace_monitor.sv
// Execution monitor: logs PC changes and memory writes into a first-word-fall-through
// trace FIFO, counts retired instructions and detects a stalled (halted) program counter.
module pc_trace_monitor #(
  parameter int PC_W        = 9,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PC_W-1:0]           pc,
  input  logic                      mem_write,
  input  logic [PC_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]         mem_wdata,
  input  logic                      clear,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic                      rd_pc_chg,
  output logic                      rd_wr,
  output logic [PC_W-1:0]           rd_pc,
  output logic [PC_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          instr_count,
  output logic                      halted,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_CYCLES);
  localparam logic [AW:0]   FULL_OCC  = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] HALT_LAST = SW'(HALT_CYCLES - 1);

  localparam logic [1:0] S_INIT       = 2'd0;
  localparam logic [1:0] S_WAIT_FIRST = 2'd1;
  localparam logic [1:0] S_RUN        = 2'd2;
  localparam logic [1:0] S_HALTED     = 2'd3;

  typedef struct packed {
    logic              pc_chg;
    logic              wr;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          entry_d, head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [PC_W-1:0] prev_pc_q, prev_pc_d;
  logic            prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic            pc_chg, wr_ev, ev, full, empty, pop, push;

  always_comb begin
    pc_chg = prev_valid_q && (pc != prev_pc_q);
    wr_ev  = prev_valid_q && mem_write;
    ev     = pc_chg || wr_ev;
    full   = (occ_q == FULL_OCC);
    empty  = (occ_q == '0);
    // clear discards both the incoming event and any pop requested that cycle
    pop    = !empty && rd_ready && !clear;
    push   = ev && (!full || pop) && !clear;

    entry_d        = '0;
    entry_d.pc_chg = pc_chg;
    entry_d.wr     = wr_ev;
    entry_d.pc     = pc;
    entry_d.addr   = wr_ev ? mem_addr : '0;
    entry_d.data   = wr_ev ? mem_wdata : '0;

    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d        = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d   = overflow_q || (ev && full && !pop);
    prev_pc_d    = pc;
    prev_valid_d = 1'b1;
    cnt_d        = (pc_chg && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    state_d  = state_q;
    stable_d = stable_q;
    case (state_q)
      S_INIT:       if (prev_valid_q) state_d = S_WAIT_FIRST;
      S_WAIT_FIRST: if (pc_chg) begin state_d = S_RUN; stable_d = '0; end
      S_RUN: begin
        if (ev)                         stable_d = '0;
        else if (stable_q == HALT_LAST) state_d  = S_HALTED;
        else                            stable_d = stable_q + SW'(1);
      end
      S_HALTED:     if (pc_chg) begin state_d = S_RUN; stable_d = '0; end
      default:      state_d = S_INIT;
    endcase

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      overflow_d   = 1'b0;
      prev_valid_d = 1'b0;
      cnt_d        = '0;
      state_d      = S_INIT;
      stable_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      overflow_q   <= 1'b0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      cnt_q        <= '0;
      state_q      <= S_INIT;
      stable_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      overflow_q   <= overflow_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      stable_q     <= stable_d;
    end
  end

  // storage is not reset; the head is masked by rd_valid so stale slots never show
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= entry_d;
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    rd_valid    = !empty;
    rd_pc_chg   = rd_valid & head.pc_chg;
    rd_wr       = rd_valid & head.wr;
    rd_pc       = rd_valid ? head.pc   : '0;
    rd_addr     = rd_valid ? head.addr : '0;
    rd_data     = rd_valid ? head.data : '0;
    occupancy   = occ_q;
    instr_count = cnt_q;
    halted      = (state_q == S_HALTED);
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the trace monitor.
module tb_pc_trace_monitor;
  localparam int PC_W = 9, DATA_W = 16, DEPTH = 16, HALT_CYCLES = 16, CNT_W = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b0, mem_write = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic [PC_W-1:0] pc = '0, mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic rd_valid, rd_pc_chg, rd_wr, halted, overflow;
  logic [PC_W-1:0] rd_pc, rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  pc_trace_monitor #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                     .HALT_CYCLES(HALT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_pc_chg(rd_pc_chg), .rd_wr(rd_wr), .rd_pc(rd_pc), .rd_addr(rd_addr),
    .rd_data(rd_data), .occupancy(occupancy), .instr_count(instr_count),
    .halted(halted), .overflow(overflow));

  typedef struct {
    logic chg;
    logic wr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  logic [PC_W-1:0] m_prev = '0;
  bit m_pv, m_run, m_halt, m_ovf;
  int m_age, m_quiet, m_cnt;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: evaluates one rising edge from the currently driven inputs
  task automatic m_step();
    bit chg, w, ev, pop;
    ent_t e;
    if (!reset || clear) begin
      mq.delete();
      m_pv = 0; m_run = 0; m_halt = 0; m_ovf = 0;
      m_age = 0; m_quiet = 0; m_cnt = 0;
      m_prev = pc;
      return;
    end
    chg = m_pv && (pc != m_prev);
    w   = m_pv && mem_write;
    ev  = chg || w;
    pop = (mq.size() != 0) && rd_ready;
    // halt: counted unchanged cycles after the first real PC change
    if (m_halt) begin
      if (chg) begin m_halt = 0; m_quiet = 0; end
    end else if (m_run) begin
      if (ev) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet >= HALT_CYCLES) m_halt = 1;
      end
    end else if (m_age >= 2 && chg) begin
      m_run = 1; m_quiet = 0;
    end
    if (pop) void'(mq.pop_front());
    if (ev) begin
      e.chg = chg; e.wr = w; e.pc = pc;
      e.addr = w ? mem_addr : '0;
      e.data = w ? mem_wdata : '0;
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
    end
    if (chg && m_cnt < CNT_MAX) m_cnt++;
    if (m_age < 2) m_age++;
    m_pv = 1;
    m_prev = pc;
  endtask

  task automatic check_all();
    ent_t h;
    bit v;
    v = (mq.size() != 0);
    if (v) h = mq[0];
    else begin h.chg = 0; h.wr = 0; h.pc = '0; h.addr = '0; h.data = '0; end
    chk("rd_valid",    32'(rd_valid),    32'(v));
    chk("rd_pc_chg",   32'(rd_pc_chg),   32'(h.chg));
    chk("rd_wr",       32'(rd_wr),       32'(h.wr));
    chk("rd_pc",       32'(rd_pc),       32'(h.pc));
    chk("rd_addr",     32'(rd_addr),     32'(h.addr));
    chk("rd_data",     32'(rd_data),     32'(h.data));
    chk("occupancy",   32'(occupancy),   32'(mq.size()));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
    chk("halted",      32'(halted),      32'(m_halt));
    chk("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #1;
    reset = 1'b0;
    cyc(); cyc();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_fields", 32'({rd_pc_chg, rd_wr, rd_pc, rd_addr, rd_data}), 32'd0);
    chk("rst_flags", 32'({halted, overflow}), 32'd0);
    reset = 1'b1;

    // stepped PC, nothing drained
    for (int v = 0; v < 4; v++) begin
      pc = PC_W'(v);
      repeat (4) cyc();
    end
    chk("s1_occ", 32'(occupancy), 32'd3);
    chk("s1_cnt", 32'(instr_count), 32'd3);
    chk("s1_head_pc", 32'(rd_pc), 32'd1);
    chk("s1_head_flags", 32'({rd_pc_chg, rd_wr}), 32'd2);

    // combined PC change + write entry
    pc = 9'd4; repeat (3) cyc();
    pc = 9'd5; mem_write = 1'b1; mem_addr = 9'd6; mem_wdata = 16'hABCD;
    cyc();
    mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    chk("s2_occ", 32'(occupancy), 32'd5);
    rd_ready = 1'b1;
    repeat (4) cyc();
    rd_ready = 1'b0;
    chk("s2_flags", 32'({rd_pc_chg, rd_wr}), 32'd3);
    chk("s2_pc", 32'(rd_pc), 32'd5);
    chk("s2_addr", 32'(rd_addr), 32'd6);
    chk("s2_data", 32'(rd_data), 32'hABCD);

    // halt after exactly 16 unchanged cycles (4 already elapsed)
    for (int k = 5; k <= 16; k++) begin
      cyc();
      chk("halt_edge", 32'(halted), (k == 16) ? 32'd1 : 32'd0);
    end
    pc = 9'd6; cyc();
    chk("halt_drop", 32'(halted), 32'd0);

    pc = 9'd7; cyc(); pc = 9'd8; cyc(); pc = 9'd9; cyc();
    chk("pre_clear_occ", 32'(occupancy), 32'd5);
    clear = 1'b1; pc = 9'd10; rd_ready = 1'b1;
    cyc();
    clear = 1'b0; rd_ready = 1'b0;
    chk("clr_occ", 32'(occupancy), 32'd0);
    chk("clr_cnt", 32'(instr_count), 32'd0);
    chk("clr_flags", 32'({halted, overflow, rd_valid}), 32'd0);

    // fill, push-while-full with pop, then overflow
    repeat (2) cyc();
    for (int i = 1; i <= 16; i++) begin
      pc = PC_W'(10 + i);
      cyc();
    end
    chk("full_occ", 32'(occupancy), 32'd16);
    chk("full_ovf", 32'(overflow), 32'd0);
    rd_ready = 1'b1; pc = 9'd27; cyc();
    chk("fullpop_occ", 32'(occupancy), 32'd16);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    rd_ready = 1'b0; pc = 9'd28; cyc();
    chk("ovf_occ", 32'(occupancy), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);

    // drain in order, then pop while empty
    rd_ready = 1'b1;
    repeat (16) cyc();
    chk("drain_valid", 32'(rd_valid), 32'd0);
    cyc();
    chk("empty_pop_occ", 32'(occupancy), 32'd0);

    // counter saturation
    for (int i = 0; i < 70; i++) begin
      pc = pc + PC_W'(1);
      cyc();
    end
    chk("cnt_sat", 32'(instr_count), 32'(CNT_MAX));
    rd_ready = 1'b0;

    // random traffic: busy phase then sparse phase so halts also occur
    for (int n = 0; n < 1200; n++) begin
      bit sparse;
      sparse = (n >= 600);
      reset = ($urandom_range(0, 249) != 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, sparse ? 29 : 3) == 0) pc = PC_W'($urandom_range(0, 15));
      mem_write = ($urandom_range(0, sparse ? 39 : 3) == 0);
      mem_addr  = PC_W'($urandom);
      mem_wdata = DATA_W'($urandom);
      rd_ready  = sparse ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      cyc();
    end
    reset = 1'b1; clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_trace_monitor.md
Name: pc_trace_monitor

Overview:
- Synthesizable execution monitor for the RISC machine; sits beside CPU and MEM in the top level.
- Detects program-counter changes and data-memory writes, and logs each event as one entry in a parametrised trace FIFO.
- Counts retired instructions and flags HALT when the PC stays constant for a programmable number of cycles.
- Trace entries are drained through a valid/ready read port to the debug display or a bench.

Parameters:
- PC_W, 9, program-counter and memory-address width.
- DATA_W, 16, memory write-data width.
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- HALT_CYCLES, 16, consecutive unchanged-PC cycles that declare a halt; at least 2.
- CNT_W, 16, instruction-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  in  PC_W  CPU program counter.
- mem_write  in  1  data-memory write strobe, sampled each cycle.
- mem_addr  in  PC_W  write address.
- mem_wdata  in  DATA_W  write data.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_pc_chg  out  1  head entry: PC-change event.
- rd_wr  out  1  head entry: memory-write event.
- rd_pc  out  PC_W  head entry: PC value after the change (current PC if no change).
- rd_addr  out  PC_W  head entry: write address (0 if rd_wr=0).
- rd_data  out  DATA_W  head entry: write data (0 if rd_wr=0).
- occupancy  out  log2(DEPTH)+1  entries held.
- instr_count  out  CNT_W  number of PC changes, saturating.
- halted  out  1  HALT detected.
- overflow  out  1  sticky; at least one event was dropped.

Behaviour:
- Reset (reset=0 at a rising edge):
  - FIFO empty; rd_valid=0; all rd_* fields 0; occupancy=0.
  - instr_count=0; halted=0; overflow=0; prev_valid=0; FSM enters INIT.
- PC tracking:
  - prev_pc is loaded with pc every cycle.
  - pc_chg = prev_valid & (pc != prev_pc).
  - The first cycle after reset or clear only loads prev_pc and sets prev_valid; it never produces an event.
- Event entry:
  - An entry is pushed in any cycle where pc_chg | mem_write is true.
  - The entry is {pc_chg, mem_write, pc, mem_addr or 0, mem_wdata or 0}.
  - Simultaneous PC change and write produce one combined entry.
- FIFO:
  - First-word-fall-through; the rd_* fields show the head combinationally from storage.
  - A pop occurs when rd_valid & rd_ready.
  - Push and pop in the same cycle are both honoured, including when full (occupancy unchanged).
  - Push when full without a pop: the entry is dropped and overflow is set, then held until reset or clear.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- instr_count:
  - Increments on each pc_chg.
  - Saturates at 2^CNT_W-1.
- Halt FSM with stable_cnt:
  - INIT: waits for prev_valid, then goes to WAIT_FIRST.
  - WAIT_FIRST: no halt detection; the first pc_chg goes to RUN with stable_cnt=0.
  - RUN:
    - pc_chg or mem_write clears stable_cnt.
    - Otherwise stable_cnt increments.
    - When stable_cnt reaches HALT_CYCLES-1 and the PC is still unchanged, go to HALTED. halted=1 from the next cycle onward.
  - HALTED: halted stays 1; a pc_chg clears halted, clears stable_cnt and returns to RUN.
- clear=1:
  - Same effect as reset on FIFO, counters, flags, prev_valid and FSM.
  - Any event in that cycle is discarded.
  - A rd_ready in that cycle pops nothing.
- Reset mid-operation: all contents are lost, the FIFO is empty the next cycle, and no partial entries are kept.
- Latency: an event at rising edge N is visible on rd_valid/rd_* after edge N.

Test Plan:
- Reset, pc held at 0, then stepped to 1, 2, 3 with 4 cycles between steps, rd_ready=0 -> occupancy=3; entries pc=1, 2, 3 with rd_pc_chg=1, rd_wr=0; instr_count=3.
- Same cycle as pc 4->5: mem_write=1, mem_addr=6, mem_wdata=16'hABCD -> one entry {pc_chg=1, wr=1, pc=5, addr=6, data=ABCD}.
- pc constant for 16 cycles after a change (HALT_CYCLES=16) -> halted rises exactly after the 16th unchanged cycle, not before. A later pc change drops halted on the next cycle.
- 17 PC changes with rd_ready=0 (DEPTH=16) -> occupancy=16, overflow=1. With DEPTH=16 and rd_ready=1, a push while full keeps occupancy=16 with no overflow.
- Drain the FIFO with rd_ready held high -> entries pop in order, one per cycle; rd_valid drops after the last entry; a further pop while empty keeps occupancy=0.
- Assert clear mid-run with occupancy=5 and a simultaneous pc change -> next cycle occupancy=0, instr_count=0, overflow=0, halted=0, no entry logged.
